// File: rtl/pong_pkg.sv
// Shared definitions for the Pong telemetry transmitter: frame layout,
// byte-index constants, FSM state encodings and the snapshot bundle.
package pong_pkg;

    localparam int         FRAME_LEN  = 8;
    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam logic [7:0] TRAILER    = 8'h0A;

    // Byte positions within a frame
    localparam logic [2:0] IDX_HDR  = 3'd0;
    localparam logic [2:0] IDX_X    = 3'd1;
    localparam logic [2:0] IDX_YB   = 3'd2;
    localparam logic [2:0] IDX_YP   = 3'd3;
    localparam logic [2:0] IDX_YA   = 3'd4;
    localparam logic [2:0] IDX_SC   = 3'd5;
    localparam logic [2:0] IDX_CHK  = 3'd6;
    localparam logic [2:0] IDX_TRL  = 3'd7;
    localparam logic [2:0] IDX_LAST = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_SEND,
        F_FIN
    } frame_state_e;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y_ball;
        logic [6:0] y_paddle;
        logic [6:0] y_ai;
        logic [7:0] score;
    } snap_t;

    function automatic logic [7:0] checksum(input snap_t s);
        return s.x
             ^ {1'b0, s.y_ball}
             ^ {1'b0, s.y_paddle}
             ^ {1'b0, s.y_ai}
             ^ s.score;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Ports: i_Clock, i_Reset (sync, active-high),
// i_TX_DV/i_TX_Byte (byte request), o_TX_Serial (line), o_TX_Active, o_TX_Done.
module uart_tx_byte
    import pong_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign o_TX_Active = (state_q != U_IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // o_TX_Done marks the final cycle of the stop bit; a request accepted
    // in that same cycle chains the next start bit with no idle gap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        data_d      = data_q;
        o_TX_Serial = 1'b1;
        o_TX_Done   = 1'b0;

        if (state_q != U_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            U_IDLE: begin
                if (i_TX_DV) begin
                    data_d  = i_TX_Byte;
                    cnt_d   = '0;
                    state_d = U_START;
                end
            end
            U_START: begin
                o_TX_Serial = 1'b0;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = U_DATA;
                end
            end
            U_DATA: begin
                o_TX_Serial = data_q[bit_q];
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                    end
                end
            end
            U_STOP: begin
                if (bit_end) begin
                    o_TX_Done = 1'b1;
                    if (i_TX_DV) begin
                        data_d  = i_TX_Byte;
                        state_d = U_START;
                    end else begin
                        state_d = U_IDLE;
                    end
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

endmodule

// File: rtl/pong_status_tx.sv
// Pong telemetry: snapshots ball/paddle/score state into an 8-byte frame
// and sends it as 8N1 UART on i_Send or on any score change.
// Ports: i_Clock, i_Reset (sync, active-high), i_Send, game-state inputs,
// o_TX_Serial (line), o_Busy (frame in flight), o_Done (frame-end pulse).
module pong_status_tx
    import pong_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] HEADER       = HEADER_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Send,
    input  logic [7:0] i_X_Ball,
    input  logic [6:0] i_Y_Ball,
    input  logic [6:0] i_Y_Paddle,
    input  logic [6:0] i_Y_Ai,
    input  logic [3:0] i_Player_Score,
    input  logic [3:0] i_Ai_Score,
    output logic       o_TX_Serial,
    output logic       o_Busy,
    output logic       o_Done
);

    frame_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         pend_q, pend_d;
    logic [7:0]   score_q, score_d;
    snap_t        snap_q, snap_d;

    logic [7:0] score_in;
    logic       trigger;
    logic [2:0] nxt_idx;
    logic [7:0] nxt_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       tx_active;

    assign score_in = {i_Player_Score, i_Ai_Score};
    assign trigger  = i_Send | (score_in != score_q);
    assign nxt_idx  = idx_q + 3'd1;

    // FIN keeps busy high only when another frame is already queued
    assign o_Busy = tx_active
                  | (state_q == F_LOAD)
                  | (state_q == F_SEND)
                  | ((state_q == F_FIN) & pend_q);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Serial(o_TX_Serial),
        .o_TX_Active(tx_active),
        .o_TX_Done  (tx_done)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= F_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            score_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        nxt_byte = TRAILER;
        case (nxt_idx)
            IDX_HDR: nxt_byte = HEADER;
            IDX_X:   nxt_byte = snap_q.x;
            IDX_YB:  nxt_byte = {1'b0, snap_q.y_ball};
            IDX_YP:  nxt_byte = {1'b0, snap_q.y_paddle};
            IDX_YA:  nxt_byte = {1'b0, snap_q.y_ai};
            IDX_SC:  nxt_byte = snap_q.score;
            IDX_CHK: nxt_byte = checksum(snap_q);
            IDX_TRL: nxt_byte = TRAILER;
            default: nxt_byte = TRAILER;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        snap_d  = snap_q;
        score_d = score_in;
        tx_dv   = 1'b0;
        tx_byte = HEADER;
        o_Done  = 1'b0;

        // Any number of triggers during a frame collapse into one
        if ((state_q != F_IDLE) && trigger) begin
            pend_d = 1'b1;
        end

        case (state_q)
            F_IDLE: begin
                if (trigger) begin
                    state_d = F_LOAD;
                end
            end
            F_LOAD: begin
                snap_d = '{x:        i_X_Ball,
                           y_ball:   i_Y_Ball,
                           y_paddle: i_Y_Paddle,
                           y_ai:     i_Y_Ai,
                           score:    score_in};
                idx_d   = '0;
                pend_d  = 1'b0;
                tx_dv   = 1'b1;
                tx_byte = HEADER;
                state_d = F_SEND;
            end
            F_SEND: begin
                if (tx_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = F_FIN;
                    end else begin
                        idx_d   = nxt_idx;
                        tx_dv   = 1'b1;
                        tx_byte = nxt_byte;
                    end
                end
            end
            F_FIN: begin
                o_Done  = 1'b1;
                state_d = (pend_q | trigger) ? F_LOAD : F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_status_tx.sv
// Self-checking bench for pong_status_tx with a line-level UART decoder
// and an arithmetic frame/bit model.
module tb_pong_status_tx;

    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 8 * BYTE_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] x;
    logic [6:0] yb;
    logic [6:0] yp;
    logic [6:0] ya;
    logic [3:0] ps;
    logic [3:0] as_s;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [63:0] fr;

    always #5 clk = ~clk;

    pong_status_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hA5)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Send        (send),
        .i_X_Ball      (x),
        .i_Y_Ball      (yb),
        .i_Y_Paddle    (yp),
        .i_Y_Ai        (ya),
        .i_Player_Score(ps),
        .i_Ai_Score    (as_s),
        .o_TX_Serial   (tx),
        .o_Busy        (busy),
        .o_Done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bytes packed little-end first: byte i at [8*i +: 8]
    function automatic logic [63:0] exp_frame(
        input logic [7:0] fx, input logic [6:0] fyb,
        input logic [6:0] fyp, input logic [6:0] fya,
        input logic [3:0] fps, input logic [3:0] fas);
        logic [7:0]  b [8];
        logic [63:0] r;
        b[0] = 8'hA5;
        b[1] = fx;
        b[2] = {1'b0, fyb};
        b[3] = {1'b0, fyp};
        b[4] = {1'b0, fya};
        b[5] = {fps, fas};
        b[6] = 8'h00;
        for (int i = 1; i <= 5; i++) b[6] = b[6] ^ b[i];
        b[7] = 8'h0A;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Expected line level t cycles after the frame's first start bit
    function automatic logic exp_line(input logic [63:0] f, input int t);
        int bi;
        int pos;
        bi  = t / BYTE_CYC;
        pos = (t % BYTE_CYC) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return f[8*bi + pos - 1];
    endfunction

    task automatic rand_fields();
        x  = 8'($urandom);
        yb = 7'($urandom);
        yp = 7'($urandom);
        ya = 7'($urandom);
    endtask

    task automatic cur_frame();
        fr = exp_frame(x, yb, yp, ya, ps, as_s);
    endtask

    // Called at the negedge of the trigger cycle; returns at start-bit negedge
    task automatic expect_load(input string tag, input bit drop_send);
        @(negedge clk);
        if (drop_send) send = 1'b0;
        chk($sformatf("%s_load_busy", tag), busy, 1);
        chk($sformatf("%s_load_line", tag), tx, 1);
        @(negedge clk);
        chk($sformatf("%s_start", tag), tx, 0);
    endtask

    // Samples a whole frame starting at the start-bit negedge; ends at FIN
    task automatic capture(input logic [63:0] f, input string tag);
        logic       line_s [FRAME_CYC];
        logic [7:0] got;
        int         bad_line;
        int         bad_busy;
        int         bad_done;
        bad_line = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int t = 0; t < FRAME_CYC; t++) begin
            if (t > 0) @(negedge clk);
            line_s[t] = tx;
            if (tx !== exp_line(f, t)) bad_line++;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
        end
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) begin
                got[j] = line_s[b*BYTE_CYC + (j+1)*CPB + CPB/2];
            end
            chk($sformatf("%s_byte%0d", tag, b), got, f[8*b +: 8]);
        end
        chk($sformatf("%s_bitwidth", tag), bad_line, 0);
        chk($sformatf("%s_busy_hold", tag), bad_busy, 0);
        chk($sformatf("%s_done_early", tag), bad_done, 0);
        @(negedge clk);
        chk($sformatf("%s_done", tag), done, 1);
    endtask

    task automatic quiet(input int n, input string tag);
        int lows;
        int dones;
        lows  = 0;
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (done !== 1'b0) dones++;
        end
        chk($sformatf("%s_line", tag), lows, 0);
        chk($sformatf("%s_nodone", tag), dones, 0);
    endtask

    task automatic reset_zero();
        @(negedge clk);
        ps   = 4'd0;
        as_s = 4'd0;
        send = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        send = 1'b0;
        x    = '0;
        yb   = '0;
        yp   = '0;
        ya   = '0;
        ps   = '0;
        as_s = '0;

        @(negedge clk);
        chk("rst_line", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet(20, "idle");

        // Directed frame
        @(negedge clk);
        x    = 8'h50;
        yb   = 7'h20;
        yp   = 7'h10;
        ya   = 7'h30;
        ps   = 4'd3;
        as_s = 4'd1;
        send = 1'b1;
        cur_frame();
        chk("t1_checksum_model", {24'd0, fr[55:48]}, 32'h61);
        expect_load("t1", 1);
        capture(fr, "t1");
        chk("t1_fin_busy", busy, 0);
        quiet(50, "t1_after");

        // Score change alone triggers exactly one frame
        reset_zero();
        quiet(10, "t2_pre");
        @(negedge clk);
        rand_fields();
        as_s = 4'd1;
        cur_frame();
        expect_load("t2", 1);
        capture(fr, "t2");
        chk("t2_fin_busy", busy, 0);
        quiet(400, "t2_after");

        // i_Send held for a whole frame -> one pending frame back-to-back
        @(negedge clk);
        rand_fields();
        send = 1'b1;
        cur_frame();
        expect_load("t3a", 0);
        capture(fr, "t3a");
        chk("t3_fin_busy", busy, 1);
        send = 1'b0;
        rand_fields();
        cur_frame();
        @(negedge clk);
        chk("t3_load2_busy", busy, 1);
        chk("t3_load2_line", tx, 1);
        @(negedge clk);
        chk("t3_start2", tx, 0);
        capture(fr, "t3b");
        chk("t3_fin2_busy", busy, 0);
        quiet(100, "t3_after");

        // X changes every cycle; frame carries the LOAD-cycle value
        @(negedge clk);
        rand_fields();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("t4_load_busy", busy, 1);
        x = 8'($urandom);
        cur_frame();
        @(negedge clk);
        chk("t4_start", tx, 0);
        fork
            capture(fr, "t4");
            repeat (FRAME_CYC + 2) begin
                @(negedge clk);
                x = 8'($urandom);
            end
        join
        chk("t4_idle_busy", busy, 0);

        // Reset during byte 3 data bits, with a frame pending
        reset_zero();
        @(negedge clk);
        rand_fields();
        send = 1'b1;
        expect_load("t5", 1);
        for (int t = 1; t <= 3*BYTE_CYC + 3*CPB; t++) begin
            @(negedge clk);
            if (t == 50) send = 1'b1;
            if (t == 51) send = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_line", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        rst = 1'b0;
        quiet(400, "t5_after");

        // Random frames
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_fields();
            ps   = 4'($urandom);
            as_s = 4'($urandom);
            send = 1'b1;
            cur_frame();
            expect_load($sformatf("r%0d", i), 1);
            capture(fr, $sformatf("r%0d", i));
            chk($sformatf("r%0d_fin_busy", i), busy, 0);
        end
        quiet(20, "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
